pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges three hazard sources into one consistent set of pipeline-register enables:
- load-use detection against the ID/EX load;
- a multi-cycle multiply/divide occupying EX;
- a taken branch resolved in ID.

It sits between the decode-stage comparators and the PC, IF/ID, ID/EX and EX-stage registers. It also keeps saturating stall and flush counters for performance measurement.

---
 rtl/pipeline_stall_controller.sv | 121 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, mult/div
// occupancy and taken-branch hazards into one set of pipeline-register enables.
module pipeline_stall_controller #(
   parameter int unsigned MULDIV_CYCLES = 4,
   parameter int unsigned COUNT_WIDTH   = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   ID_EX_MemRead,
   input  logic [4:0]             ID_EX_RegisterRt,
   input  logic [4:0]             IF_ID_RegisterRs,
   input  logic [4:0]             IF_ID_RegisterRt,
   input  logic                   BranchTaken,
   input  logic                   EX_MulDivStart,
   output logic                   PCWrite,
   output logic                   IF_ID_Write,
   output logic                   IF_ID_Flush,
   output logic                   ID_EX_Bubble,
   output logic                   EX_Hold,
   output logic                   MulDivBusy,
   output logic [COUNT_WIDTH-1:0] StallCycles,
   output logic [COUNT_WIDTH-1:0] FlushCount
);

   localparam int unsigned MD_W = 4;
   localparam logic [MD_W-1:0] MD_LOAD =
      MD_W'((MULDIV_CYCLES > 2) ? (MULDIV_CYCLES - 3) : 0);
   localparam logic SHORT_MD = (MULDIV_CYCLES <= 2);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [MD_W-1:0] md_cnt, md_cnt_nxt;
   logic            load_use;

   // $zero is never a real dependency, so a load targeting it cannot stall
   assign load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                     ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                      (ID_EX_RegisterRt == IF_ID_RegisterRt));

   // Next-state and enables; priority in RUN is mult/div > load-use > branch
   always_comb begin
      state_nxt    = state;
      md_cnt_nxt   = md_cnt;
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      EX_Hold      = 1'b0;
      MulDivBusy   = 1'b0;

      if (Reset) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
         state_nxt    = RUN;
         md_cnt_nxt   = '0;
      end else begin
         unique case (state)
            RUN: begin
               if (EX_MulDivStart) begin
                  EX_Hold     = 1'b1;
                  PCWrite     = 1'b0;
                  IF_ID_Write = 1'b0;
                  if (!SHORT_MD) begin
                     md_cnt_nxt = MD_LOAD;
                     state_nxt  = MD_WAIT;
                  end
               end else if (load_use) begin
                  PCWrite      = 1'b0;
                  IF_ID_Write  = 1'b0;
                  ID_EX_Bubble = 1'b1;
               end else if (BranchTaken) begin
                  IF_ID_Flush = 1'b1;
               end
            end
            MD_WAIT: begin
               EX_Hold     = 1'b1;
               PCWrite     = 1'b0;
               IF_ID_Write = 1'b0;
               MulDivBusy  = 1'b1;
               if (md_cnt == '0) begin
                  state_nxt = RUN;
               end else begin
                  md_cnt_nxt = md_cnt - MD_W'(1);
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // FSM state and mult/div down-counter
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // Saturating performance counters, one edge behind the counted cycle
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         StallCycles <= '0;
         FlushCount  <= '0;
      end else begin
         if (!PCWrite && (StallCycles != CNT_MAX))
            StallCycles <= StallCycles + COUNT_WIDTH'(1);
         if (IF_ID_Flush && (FlushCount != CNT_MAX))
            FlushCount <= FlushCount + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: default build, a 4-bit counter
// build for saturation, and a 2-cycle mult/div build, all on shared inputs.
module tb_pipeline_stall_controller;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       ID_EX_MemRead;
   logic [4:0] ID_EX_RegisterRt;
   logic [4:0] IF_ID_RegisterRs;
   logic [4:0] IF_ID_RegisterRt;
   logic       BranchTaken;
   logic       EX_MulDivStart;

   logic        pc_w, ifid_w, flush, bubble, hold, busy;
   logic [15:0] stall_cnt, flush_cnt;
   logic        c4_pc_w, c4_ifid_w, c4_flush, c4_bubble, c4_hold, c4_busy;
   logic [3:0]  c4_stall, c4_flushc;
   logic        m2_pc_w, m2_ifid_w, m2_flush, m2_bubble, m2_hold, m2_busy;
   logic [15:0] m2_stall, m2_flushc;

   logic [5:0] ctl;
   assign ctl = {pc_w, ifid_w, flush, bubble, hold, busy};

   int total = 0;
   int bad   = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   always #5 Clk = ~Clk;

   pipeline_stall_controller u_dut (
      .Clk(Clk), .Reset(Reset), .ID_EX_MemRead(ID_EX_MemRead),
      .ID_EX_RegisterRt(ID_EX_RegisterRt), .IF_ID_RegisterRs(IF_ID_RegisterRs),
      .IF_ID_RegisterRt(IF_ID_RegisterRt), .BranchTaken(BranchTaken),
      .EX_MulDivStart(EX_MulDivStart), .PCWrite(pc_w), .IF_ID_Write(ifid_w),
      .IF_ID_Flush(flush), .ID_EX_Bubble(bubble), .EX_Hold(hold),
      .MulDivBusy(busy), .StallCycles(stall_cnt), .FlushCount(flush_cnt)
   );

   pipeline_stall_controller #(.MULDIV_CYCLES(4), .COUNT_WIDTH(4)) u_cw4 (
      .Clk(Clk), .Reset(Reset), .ID_EX_MemRead(ID_EX_MemRead),
      .ID_EX_RegisterRt(ID_EX_RegisterRt), .IF_ID_RegisterRs(IF_ID_RegisterRs),
      .IF_ID_RegisterRt(IF_ID_RegisterRt), .BranchTaken(BranchTaken),
      .EX_MulDivStart(EX_MulDivStart), .PCWrite(c4_pc_w), .IF_ID_Write(c4_ifid_w),
      .IF_ID_Flush(c4_flush), .ID_EX_Bubble(c4_bubble), .EX_Hold(c4_hold),
      .MulDivBusy(c4_busy), .StallCycles(c4_stall), .FlushCount(c4_flushc)
   );

   pipeline_stall_controller #(.MULDIV_CYCLES(2), .COUNT_WIDTH(16)) u_md2 (
      .Clk(Clk), .Reset(Reset), .ID_EX_MemRead(ID_EX_MemRead),
      .ID_EX_RegisterRt(ID_EX_RegisterRt), .IF_ID_RegisterRs(IF_ID_RegisterRs),
      .IF_ID_RegisterRt(IF_ID_RegisterRt), .BranchTaken(BranchTaken),
      .EX_MulDivStart(EX_MulDivStart), .PCWrite(m2_pc_w), .IF_ID_Write(m2_ifid_w),
      .IF_ID_Flush(m2_flush), .ID_EX_Bubble(m2_bubble), .EX_Hold(m2_hold),
      .MulDivBusy(m2_busy), .StallCycles(m2_stall), .FlushCount(m2_flushc)
   );

   task automatic set_in(input logic mr, input logic [4:0] ex_rt,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic br, input logic md);
      ID_EX_MemRead    = mr;
      ID_EX_RegisterRt = ex_rt;
      IF_ID_RegisterRs = rs;
      IF_ID_RegisterRt = rt;
      BranchTaken      = br;
      EX_MulDivStart   = md;
   endtask

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #2;
      total++;
      if (ctl !== 6'b000100) begin
         $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b000100); bad++;
      end
      total++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); bad++;
      end
      next_cycle();
      next_cycle();
      Reset = 1'b0;
      #1;
      total++;
      if (ctl !== 6'b110000) begin
         $display("FAIL release_ctl got=%b exp=%b", ctl, 6'b110000); bad++;
      end
      next_cycle();
      total++;
      if (stall_cnt !== 16'd0) begin
         $display("FAIL release_stall got=%0d exp=0", stall_cnt); bad++;
      end
   endtask

   task automatic test_load_use();
      // match on rs
      set_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
      #1;
      total++;
      if (ctl !== 6'b000100) begin
         $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, 6'b000100); bad++;
      end
      next_cycle();
      exp_stall = 1;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      total++;
      if (stall_cnt !== 16'(exp_stall) || ctl !== 6'b110000) begin
         $display("FAIL lu_rs_after got=%0d ctl=%b exp=%0d ctl=110000", stall_cnt, ctl, exp_stall); bad++;
      end
      // match on rt
      set_in(1'b1, 5'd17, 5'd2, 5'd17, 1'b0, 1'b0);
      #1;
      total++;
      if (ctl !== 6'b000100) begin
         $display("FAIL lu_rt_ctl got=%b exp=%b", ctl, 6'b000100); bad++;
      end
      next_cycle();
      exp_stall = 2;
      // no load, registers match: no stall
      set_in(1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
      #1;
      total++;
      if (ctl !== 6'b110000) begin
         $display("FAIL noload_ctl got=%b exp=%b", ctl, 6'b110000); bad++;
      end
      next_cycle();
      total++;
      if (stall_cnt !== 16'(exp_stall)) begin
         $display("FAIL lu_rt_stall got=%0d exp=%0d", stall_cnt, exp_stall); bad++;
      end
   endtask

   task automatic test_zero_filter();
      set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      total++;
      if (ctl !== 6'b110000) begin
         $display("FAIL zero_ctl got=%b exp=%b", ctl, 6'b110000); bad++;
      end
      next_cycle();
      total++;
      if (stall_cnt !== 16'(exp_stall)) begin
         $display("FAIL zero_stall got=%0d exp=%0d", stall_cnt, exp_stall); bad++;
      end
   endtask

   task automatic test_branch_vs_load_use();
      set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0);
      #1;
      total++;
      if (ctl !== 6'b000100) begin
         $display("FAIL br_lu_ctl got=%b exp=%b", ctl, 6'b000100); bad++;
      end
      next_cycle();
      exp_stall++;
      set_in(1'b0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0);
      #1;
      total++;
      if (ctl !== 6'b111000) begin
         $display("FAIL br_ctl got=%b exp=%b", ctl, 6'b111000); bad++;
      end
      next_cycle();
      exp_flush++;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      total++;
      if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
         $display("FAIL br_cnt got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall); bad++;
      end
   endtask

   task automatic test_muldiv(input logic br);
      set_in(1'b0, 5'd0, 5'd0, 5'd0, br, 1'b1);
      #1;
      total++;
      if (ctl !== 6'b000010 || m2_hold !== 1'b1) begin
         $display("FAIL md_c0 br=%b got=%b m2hold=%b exp=000010 m2hold=1", br, ctl, m2_hold); bad++;
      end
      next_cycle();
      EX_MulDivStart = 1'b0;
      // a load-use pattern during the wait must not produce a bubble
      ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd5;
      #1;
      total++;
      if (ctl !== 6'b000011) begin
         $display("FAIL md_c1 br=%b got=%b exp=%b", br, ctl, 6'b000011); bad++;
      end
      total++;
      if ({m2_hold, m2_busy} !== 2'b00) begin
         $display("FAIL md2_c1 got=%b exp=00", {m2_hold, m2_busy}); bad++;
      end
      next_cycle();
      ID_EX_MemRead = 1'b0;
      #1;
      total++;
      if (ctl !== 6'b000011) begin
         $display("FAIL md_c2 br=%b got=%b exp=%b", br, ctl, 6'b000011); bad++;
      end
      next_cycle();
      #1;
      total++;
      if (ctl !== {4'b11, br, 3'b000}) begin
         $display("FAIL md_c3 br=%b got=%b exp=%b", br, ctl, {2'b11, br, 3'b000}); bad++;
      end
      next_cycle();
      exp_stall += 3;
      if (br) exp_flush++;
      BranchTaken = 1'b0;
      total++;
      if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin
         $display("FAIL md_cnt br=%b got=%0d/%0d exp=%0d/%0d", br, stall_cnt, flush_cnt, exp_stall, exp_flush); bad++;
      end
   endtask

   task automatic test_reset_mid_wait();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      next_cycle();
      EX_MulDivStart = 1'b0;
      next_cycle();
      #1;
      total++;
      if (ctl !== 6'b000011) begin
         $display("FAIL rmw_wait got=%b exp=%b", ctl, 6'b000011); bad++;
      end
      Reset = 1'b1;
      #1;
      total++;
      if (ctl !== 6'b000100) begin
         $display("FAIL rmw_ctl got=%b exp=%b", ctl, 6'b000100); bad++;
      end
      total++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || c4_stall !== 4'd0) begin
         $display("FAIL rmw_cnt got=%0d/%0d/%0d exp=0/0/0", stall_cnt, flush_cnt, c4_stall); bad++;
      end
      next_cycle();
      Reset = 1'b0;
      #1;
      total++;
      if (ctl !== 6'b110000) begin
         $display("FAIL rmw_release got=%b exp=%b", ctl, 6'b110000); bad++;
      end
      next_cycle();
      exp_stall = 0;
      exp_flush = 0;
      total++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         $display("FAIL rmw_after got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); bad++;
      end
   endtask

   task automatic test_saturation();
      set_in(1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         next_cycle();
         total++;
         if (c4_stall !== 4'((i < 15) ? i : 15)) begin
            $display("FAIL sat_step%0d got=%0d exp=%0d", i, c4_stall, (i < 15) ? i : 15); bad++;
         end
      end
      exp_stall = 20;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      total++;
      if (c4_stall !== 4'd15 || stall_cnt !== 16'(exp_stall)) begin
         $display("FAIL sat_hold got=%0d/%0d exp=15/%0d", c4_stall, stall_cnt, exp_stall); bad++;
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_filter();
      test_branch_vs_load_use();
      test_muldiv(1'b0);
      test_muldiv(1'b1);
      test_reset_mid_wait();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
